// File: rtl/ram64x18_pkg.sv
// rtl/ram64x18_pkg.sv - shared constants and width decode for the 64x18 micro-RAM
package ram64x18_pkg;

  localparam logic [2:0] WIDTH_X8  = 3'b011;
  localparam logic [2:0] WIDTH_X18 = 3'b100;

  localparam int ROWS      = 64;
  localparam int ROW_BITS  = 18;
  localparam int LANE_BITS = 9;
  localparam int ROW_AW    = 6;

  // Only the x8 code selects byte-lane access; x18 and every unknown code use whole rows.
  function automatic logic is_x8(input logic [2:0] width);
    logic x8;
    case (width)
      WIDTH_X8:  x8 = 1'b1;
      WIDTH_X18: x8 = 1'b0;
      default:   x8 = 1'b0;
    endcase
    return x8;
  endfunction

endpackage

// File: rtl/ram64x18_rd_port.sv
// rtl/ram64x18_rd_port.sv - one read port: address register, width slicing, optional output register
module ram64x18_rd_port
  import ram64x18_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [9:0]          addr,
  input  logic [1:0]          blk,
  input  logic                en,
  input  logic                dout_lat,
  input  logic [2:0]          width,
  output logic [ROW_AW-1:0]   row,
  input  logic [ROW_BITS-1:0] row_data,
  output logic [ROW_BITS-1:0] dout
);

  // Row is addr[9:4] in both widths; addr[3] picks the lane in x8 mode, addr[2:0] never matters.
  logic [9:3]          addr_q;
  logic                sel_q;
  logic [ROW_BITS-1:0] rd_data;
  logic [ROW_BITS-1:0] out_q;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^addr[2:0];

  // Address register with the block-select flag; holds while en is low.
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      sel_q  <= 1'b0;
    end else if (en) begin
      addr_q <= addr[9:3];
      sel_q  <= (blk == 2'b11);
    end
  end

  assign row = addr_q[9:4];

  // Width slice of the addressed row; a deselected port reads as zero.
  always_comb begin
    rd_data = '0;
    if (sel_q) begin
      if (is_x8(width)) begin
        if (addr_q[3]) begin
          rd_data = {{(ROW_BITS-8){1'b0}}, row_data[LANE_BITS +: 8]};
        end else begin
          rd_data = {{(ROW_BITS-8){1'b0}}, row_data[0 +: 8]};
        end
      end else begin
        rd_data = row_data;
      end
    end
  end

  // Extra pipeline stage used when the port is configured for registered output.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
    end else begin
      out_q <= rd_data;
    end
  end

  assign dout = dout_lat ? rd_data : out_q;

endmodule

// File: rtl/ram64x18.sv
// rtl/ram64x18.sv - 64x18 micro-RAM with two read ports and one write port
module ram64x18
  import ram64x18_pkg::*;
#(
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  a_addr,
  input  logic [1:0]  a_blk,
  input  logic        a_en,
  input  logic        a_dout_lat,
  input  logic [2:0]  a_width,
  output logic [17:0] a_dout,
  input  logic [9:0]  b_addr,
  input  logic [1:0]  b_blk,
  input  logic        b_en,
  input  logic        b_dout_lat,
  input  logic [2:0]  b_width,
  output logic [17:0] b_dout,
  input  logic [9:0]  c_addr,
  input  logic [17:0] c_din,
  input  logic        c_wen,
  input  logic [1:0]  c_blk,
  input  logic        c_en,
  input  logic [2:0]  c_width,
  output logic        busy
);

  logic [ROW_BITS-1:0] mem [ROWS];
  logic [ROW_AW-1:0]   c_row;
  logic                c_lane;
  logic                c_fire;
  logic [ROW_AW-1:0]   a_row;
  logic [ROW_AW-1:0]   b_row;
  logic [ROW_BITS-1:0] a_row_data;
  logic [ROW_BITS-1:0] b_row_data;
  logic                unused_c_bits;

  assign c_row         = c_addr[9:4];
  assign c_lane        = c_addr[3];
  assign c_fire        = c_en & c_wen & (c_blk == 2'b11);
  assign unused_c_bits = ^c_addr[2:0];
  assign busy          = 1'b0;

  // Storage update; reset blocks any write on the same edge, and optionally wipes the array.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (CLEAR_ON_RESET) begin
        for (int i = 0; i < ROWS; i++) begin
          mem[i] <= '0;
        end
      end
    end else if (c_fire) begin
      if (is_x8(c_width)) begin
        if (c_lane) begin
          mem[c_row][LANE_BITS +: 8] <= c_din[7:0];
        end else begin
          mem[c_row][0 +: 8] <= c_din[7:0];
        end
      end else begin
        mem[c_row] <= c_din;
      end
    end
  end

  assign a_row_data = mem[a_row];
  assign b_row_data = mem[b_row];

  ram64x18_rd_port u_rd_a (
    .clock    (clock),
    .reset    (reset),
    .addr     (a_addr),
    .blk      (a_blk),
    .en       (a_en),
    .dout_lat (a_dout_lat),
    .width    (a_width),
    .row      (a_row),
    .row_data (a_row_data),
    .dout     (a_dout)
  );

  ram64x18_rd_port u_rd_b (
    .clock    (clock),
    .reset    (reset),
    .addr     (b_addr),
    .blk      (b_blk),
    .en       (b_en),
    .dout_lat (b_dout_lat),
    .width    (b_width),
    .row      (b_row),
    .row_data (b_row_data),
    .dout     (b_dout)
  );

endmodule

// File: tb/tb_ram64x18.sv
// tb/tb_ram64x18.sv - self-checking bench for ram64x18 against a lane-array reference model
module tb_ram64x18;

  localparam logic [2:0] X8  = 3'b011;
  localparam logic [2:0] X18 = 3'b100;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  a_addr = '0;
  logic [1:0]  a_blk = '0;
  logic        a_en = 1'b0;
  logic        a_dout_lat = 1'b1;
  logic [2:0]  a_width = X18;
  logic [17:0] a_dout;
  logic [9:0]  b_addr = '0;
  logic [1:0]  b_blk = '0;
  logic        b_en = 1'b0;
  logic        b_dout_lat = 1'b1;
  logic [2:0]  b_width = X18;
  logic [17:0] b_dout;
  logic [9:0]  c_addr = '0;
  logic [17:0] c_din = '0;
  logic        c_wen = 1'b0;
  logic [1:0]  c_blk = 2'b11;
  logic        c_en = 1'b0;
  logic [2:0]  c_width = X18;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference memory: 128 nine-bit lanes; x8 word k is lane k, x18 row r is {lane 2r+1, lane 2r}.
  logic [8:0] lanes [128];

  always #5 clock = ~clock;

  ram64x18 #(.CLEAR_ON_RESET(1'b0)) dut (
    .clock(clock), .reset(reset),
    .a_addr(a_addr), .a_blk(a_blk), .a_en(a_en), .a_dout_lat(a_dout_lat), .a_width(a_width), .a_dout(a_dout),
    .b_addr(b_addr), .b_blk(b_blk), .b_en(b_en), .b_dout_lat(b_dout_lat), .b_width(b_width), .b_dout(b_dout),
    .c_addr(c_addr), .c_din(c_din), .c_wen(c_wen), .c_blk(c_blk), .c_en(c_en), .c_width(c_width),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [17:0] model_read(input logic [9:0] addr, input logic [1:0] blk, input logic [2:0] width);
    int w;
    int r;
    if (blk != 2'b11) return 18'h0;
    if (width == X8) begin
      w = int'(addr[9:3]);
      return {10'h0, lanes[w][7:0]};
    end
    r = int'(addr[9:4]);
    return {lanes[2*r+1], lanes[2*r]};
  endfunction

  task automatic do_write(input logic [9:0] addr, input logic [17:0] din, input logic [2:0] width, input logic [1:0] blk);
    int w;
    int r;
    c_addr = addr; c_din = din; c_width = width; c_blk = blk; c_en = 1'b1; c_wen = 1'b1;
    tick();
    c_en = 1'b0; c_wen = 1'b0; c_blk = 2'b11;
    if (blk == 2'b11) begin
      if (width == X8) begin
        w = int'(addr[9:3]);
        lanes[w][7:0] = din[7:0];
      end else begin
        r = int'(addr[9:4]);
        lanes[2*r]   = din[8:0];
        lanes[2*r+1] = din[17:9];
      end
    end
  endtask

  task automatic set_a(input logic [9:0] addr, input logic [1:0] blk, input logic [2:0] width, input logic lat);
    a_addr = addr; a_blk = blk; a_width = width; a_dout_lat = lat; a_en = 1'b1;
  endtask

  task automatic set_b(input logic [9:0] addr, input logic [1:0] blk, input logic [2:0] width, input logic lat);
    b_addr = addr; b_blk = blk; b_width = width; b_dout_lat = lat; b_en = 1'b1;
  endtask

  task automatic clear_en();
    a_en = 1'b0; b_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (a_dout !== 18'h0) begin errors++; $display("FAIL reset_a_dout got=%h exp=%h", a_dout, 18'h0); end
    checks++; if (b_dout !== 18'h0) begin errors++; $display("FAIL reset_b_dout got=%h exp=%h", b_dout, 18'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy got=%b exp=0", busy); end
  endtask

  task automatic fill_rows();
    for (int r = 0; r < 64; r++) begin
      do_write({r[5:0], 4'h0}, 18'($urandom), X18, 2'b11);
    end
  endtask

  task automatic test_x18_random();
    logic [17:0] exp_a;
    logic [17:0] exp_b;
    int ra;
    int rb;
    for (int i = 0; i < 16; i++) begin
      ra = $urandom_range(63);
      rb = $urandom_range(63);
      set_a({ra[5:0], 4'(i)}, 2'b11, X18, 1'b1);
      set_b({rb[5:0], 4'h0}, 2'b11, 3'b000, 1'b1);
      exp_a = model_read(a_addr, 2'b11, X18);
      exp_b = model_read(b_addr, 2'b11, X18);
      tick();
      clear_en();
      checks++; if (a_dout !== exp_a) begin errors++; $display("FAIL x18_read_a row=%0d got=%h exp=%h", ra, a_dout, exp_a); end
      checks++; if (b_dout !== exp_b) begin errors++; $display("FAIL x18_read_b_othercode row=%0d got=%h exp=%h", rb, b_dout, exp_b); end
      a_addr = {6'(ra + 1), 4'h0};
      tick();
      checks++; if (a_dout !== exp_a) begin errors++; $display("FAIL addr_hold row=%0d got=%h exp=%h", ra, a_dout, exp_a); end
    end
  endtask

  task automatic test_x8_basic();
    logic [17:0] exp_row;
    do_write({7'd5, 3'b000}, {10'h3AA, 8'hA5}, X8, 2'b11);
    set_a({7'd5, 3'b000}, 2'b11, X8, 1'b1);
    tick();
    clear_en();
    checks++; if (a_dout !== 18'h000A5) begin errors++; $display("FAIL x8_a5 got=%h exp=%h", a_dout, 18'h000A5); end
    exp_row = model_read({6'd2, 4'h0}, 2'b11, X18);
    set_a({6'd2, 4'h0}, 2'b11, X18, 1'b1);
    tick();
    clear_en();
    checks++; if (a_dout !== exp_row) begin errors++; $display("FAIL x8_lane_bit8_kept got=%h exp=%h", a_dout, exp_row); end
  endtask

  task automatic test_x8_pack();
    logic [17:0] exp_row;
    do_write({7'd4, 3'b000}, 18'h00011, X8, 2'b11);
    do_write({7'd5, 3'b000}, 18'h3FF22, X8, 2'b11);
    exp_row = model_read({6'd2, 4'h0}, 2'b11, X18);
    set_a({6'd2, 4'h0}, 2'b11, X18, 1'b1);
    tick();
    clear_en();
    checks++; if (a_dout[7:0] !== 8'h11) begin errors++; $display("FAIL pack_lane0 got=%h exp=11", a_dout[7:0]); end
    checks++; if (a_dout[16:9] !== 8'h22) begin errors++; $display("FAIL pack_lane1 got=%h exp=22", a_dout[16:9]); end
    checks++; if (a_dout !== exp_row) begin errors++; $display("FAIL pack_row got=%h exp=%h", a_dout, exp_row); end
  endtask

  task automatic test_ring();
    for (int k = 0; k < 128; k++) begin
      do_write({k[6:0], 3'b000}, 18'(k), X8, 2'b11);
    end
    set_a({7'd127, 3'b000}, 2'b11, X8, 1'b1);
    set_b({7'd64, 3'b000}, 2'b11, X8, 1'b1);
    tick();
    clear_en();
    checks++; if (a_dout !== 18'h0007F) begin errors++; $display("FAIL ring_127 got=%h exp=%h", a_dout, 18'h0007F); end
    checks++; if (b_dout !== 18'h00040) begin errors++; $display("FAIL ring_b64 got=%h exp=%h", b_dout, 18'h00040); end
    set_a({7'd0, 3'b000}, 2'b11, X8, 1'b1);
    set_b({7'd1, 3'b000}, 2'b11, X8, 1'b1);
    tick();
    clear_en();
    checks++; if (a_dout !== 18'h00000) begin errors++; $display("FAIL ring_0 got=%h exp=%h", a_dout, 18'h0); end
    checks++; if (b_dout !== 18'h00001) begin errors++; $display("FAIL ring_b1 got=%h exp=%h", b_dout, 18'h1); end
  endtask

  task automatic test_deselect();
    logic [17:0] exp_v;
    set_a({7'd5, 3'b000}, 2'b00, X8, 1'b1);
    tick();
    clear_en();
    checks++; if (a_dout !== 18'h0) begin errors++; $display("FAIL deselect_read got=%h exp=0", a_dout); end
    do_write({7'd9, 3'b000}, 18'h000EE, X8, 2'b01);
    do_write({6'd7, 4'h0}, 18'h3FFFF, X18, 2'b10);
    exp_v = model_read({7'd9, 3'b000}, 2'b11, X8);
    set_a({7'd9, 3'b000}, 2'b11, X8, 1'b1);
    tick();
    clear_en();
    checks++; if (a_dout !== exp_v) begin errors++; $display("FAIL deselect_write_x8 got=%h exp=%h", a_dout, exp_v); end
    exp_v = model_read({6'd7, 4'h0}, 2'b11, X18);
    set_a({6'd7, 4'h0}, 2'b11, X18, 1'b1);
    tick();
    clear_en();
    checks++; if (a_dout !== exp_v) begin errors++; $display("FAIL deselect_write_x18 got=%h exp=%h", a_dout, exp_v); end
  endtask

  task automatic test_lat0();
    logic [17:0] exp_old;
    logic [17:0] exp_new;
    exp_old = model_read({7'd20, 3'b000}, 2'b11, X8);
    exp_new = model_read({7'd100, 3'b000}, 2'b11, X8);
    set_a({7'd20, 3'b000}, 2'b11, X8, 1'b0);
    tick();
    tick();
    clear_en();
    set_a({7'd100, 3'b000}, 2'b11, X8, 1'b0);
    tick();
    clear_en();
    checks++; if (a_dout !== exp_old) begin errors++; $display("FAIL lat0_one_cycle got=%h exp=%h", a_dout, exp_old); end
    tick();
    checks++; if (a_dout !== exp_new) begin errors++; $display("FAIL lat0_two_cycle got=%h exp=%h", a_dout, exp_new); end
    a_dout_lat = 1'b1;
  endtask

  task automatic test_random_mix();
    logic [9:0]  wa;
    logic [1:0]  wb;
    logic [2:0]  ww;
    logic [9:0]  ra;
    logic [9:0]  rb;
    logic [1:0]  ba;
    logic [1:0]  bb;
    logic [2:0]  wda;
    logic [2:0]  wdb;
    logic [17:0] exp_a;
    logic [17:0] exp_b;
    for (int i = 0; i < 60; i++) begin
      wa = 10'($urandom);
      wb = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b11;
      ww = ($urandom_range(1) == 0) ? X8 : X18;
      do_write(wa, 18'($urandom), ww, wb);
      ra = 10'($urandom);
      rb = 10'($urandom);
      ba = ($urandom_range(4) == 0) ? 2'($urandom) : 2'b11;
      bb = ($urandom_range(4) == 0) ? 2'($urandom) : 2'b11;
      wda = ($urandom_range(1) == 0) ? X8 : 3'($urandom);
      wdb = ($urandom_range(1) == 0) ? X8 : X18;
      set_a(ra, ba, wda, 1'b1);
      set_b(rb, bb, wdb, 1'b1);
      exp_a = model_read(ra, ba, wda);
      exp_b = model_read(rb, bb, wdb);
      tick();
      clear_en();
      checks++; if (a_dout !== exp_a) begin errors++; $display("FAIL mix_a i=%0d addr=%h blk=%b w=%b got=%h exp=%h", i, ra, ba, wda, a_dout, exp_a); end
      checks++; if (b_dout !== exp_b) begin errors++; $display("FAIL mix_b i=%0d addr=%h blk=%b w=%b got=%h exp=%h", i, rb, bb, wdb, b_dout, exp_b); end
    end
  endtask

  task automatic test_reset_mid();
    logic [17:0] exp_a;
    logic [17:0] exp_b;
    do_write({7'd10, 3'b000}, 18'h0005A, X8, 2'b11);
    exp_a = model_read({7'd10, 3'b000}, 2'b11, X8);
    exp_b = model_read({6'd5, 4'h0}, 2'b11, X18);
    set_a({7'd10, 3'b000}, 2'b11, X8, 1'b1);
    set_b({6'd5, 4'h0}, 2'b11, X18, 1'b0);
    tick();
    tick();
    clear_en();
    checks++; if (a_dout !== exp_a) begin errors++; $display("FAIL pre_reset_a got=%h exp=%h", a_dout, exp_a); end
    checks++; if (b_dout !== exp_b) begin errors++; $display("FAIL pre_reset_b got=%h exp=%h", b_dout, exp_b); end
    c_addr = {7'd10, 3'b000}; c_din = 18'h000F5; c_width = X8; c_blk = 2'b11; c_en = 1'b1; c_wen = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c_en = 1'b0; c_wen = 1'b0;
    checks++; if (a_dout !== 18'h0) begin errors++; $display("FAIL reset_mid_a got=%h exp=0", a_dout); end
    checks++; if (b_dout !== 18'h0) begin errors++; $display("FAIL reset_mid_b got=%h exp=0", b_dout); end
    set_a({7'd10, 3'b000}, 2'b11, X8, 1'b1);
    set_b({6'd5, 4'h0}, 2'b11, X18, 1'b1);
    tick();
    clear_en();
    checks++; if (a_dout !== exp_a) begin errors++; $display("FAIL post_reset_suppressed_write got=%h exp=%h", a_dout, exp_a); end
    checks++; if (b_dout !== exp_b) begin errors++; $display("FAIL post_reset_retained got=%h exp=%h", b_dout, exp_b); end
  endtask

  initial begin
    tick();
    test_reset();
    fill_rows();
    test_x18_random();
    test_x8_basic();
    test_x8_pack();
    test_ring();
    test_deselect();
    test_lat0();
    test_random_mix();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
